nn_layer_sequencer: RTL and testbench

//  Parametrised layer sequencer for the MLP datapath. Runs up to MAX_LAYERS

---
 rtl/nn_layer_sequencer_if.sv | 40 ++++
 rtl/nn_layer_sequencer.sv | 121 ++++++++++++
 tb/tb_nn_layer_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Handshake bundle between the MLP layer sequencer and its controller.
// NN_SEQ_ABORT_EN adds the abort request and aborted status signals.
interface nn_layer_sequencer_if #(
  parameter int MAX_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int CNT_W      = 16
) ();
  logic                        start;
  logic [LAYER_W:0]            num_layers;
  logic [MAX_LAYERS*CNT_W-1:0] layer_len;
  logic                        stall;
  logic                        neuron_start;
  logic [CNT_W-1:0]            counter;
  logic [LAYER_W-1:0]          pass;
  logic [MAX_LAYERS-1:0]       layer_we;
  logic                        busy;
  logic                        done;
`ifdef NN_SEQ_ABORT_EN
  logic                        abort;
  logic                        aborted;
`endif

  modport master (
    output start, num_layers, layer_len, stall,
    input  neuron_start, counter, pass, layer_we, busy, done
`ifdef NN_SEQ_ABORT_EN
    , output abort
    , input  aborted
`endif
  );

  modport slave (
    input  start, num_layers, layer_len, stall,
    output neuron_start, counter, pass, layer_we, busy, done
`ifdef NN_SEQ_ABORT_EN
    , input  abort
    , output aborted
`endif
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: steps the shared neuron array through up to MAX_LAYERS passes.
// Optional NN_SEQ_ABORT_EN adds an abort request that returns to IDLE mid-inference.
module nn_layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  nn_layer_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LAYER_W:0] MAX_NL = (LAYER_W+1)'(MAX_LAYERS);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_counter;
  logic [LAYER_W-1:0]    r_pass;
  logic [LAYER_W:0]      r_nl;
  logic [LAYER_W:0]      w_nl_clamp;
  logic [CNT_W-1:0]      w_len;
  logic [MAX_LAYERS-1:0] w_we;
  logic                  w_last;
  logic                  w_active;
  logic                  w_abort;

  assign w_active = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_LATCH);

`ifdef NN_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort     = bus.abort && w_active;
  assign bus.aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_nl_clamp = bus.num_layers;
    if (bus.num_layers == '0)
      w_nl_clamp = (LAYER_W+1)'(1);
    else if (bus.num_layers > MAX_NL)
      w_nl_clamp = MAX_NL;
  end

  always_comb begin
    w_len = '0;
    for (int i = 0; i < MAX_LAYERS; i++)
      if (r_pass == LAYER_W'(i))
        w_len = bus.layer_len[i*CNT_W +: CNT_W];
  end

  assign w_last = ({1'b0, r_pass} == (r_nl - 1'b1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (!bus.stall && (r_counter == '0)) w_next = S_LATCH;
      S_LATCH: w_next = w_last ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort outranks both stall and the LATCH decision.
    if (w_abort)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
      r_pass    <= '0;
      r_nl      <= (LAYER_W+1)'(1);
`ifdef NN_SEQ_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
`ifdef NN_SEQ_ABORT_EN
      r_aborted <= w_abort;
`endif
      if (!w_abort) begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_nl   <= w_nl_clamp;
              r_pass <= '0;
            end
          end
          S_LOAD:  r_counter <= w_len;
          S_RUN:   if (!bus.stall && (r_counter != '0)) r_counter <= r_counter - 1'b1;
          S_LATCH: if (!w_last) r_pass <= r_pass + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_we = '0;
    if (r_state == S_LATCH)
      for (int i = 0; i < MAX_LAYERS; i++)
        if (r_pass == LAYER_W'(i))
          w_we[i] = 1'b1;
  end

  assign bus.neuron_start = (r_state == S_LOAD);
  assign bus.busy         = w_active;
  assign bus.done         = (r_state == S_DONE);
  assign bus.counter      = r_counter;
  assign bus.pass         = r_pass;
  assign bus.layer_we     = w_we;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed, table-driven bench for nn_layer_sequencer (MAX_LAYERS=4, CNT_W=16).
module tb_nn_layer_sequencer;
  localparam int ML = 4;
  localparam int LW = 2;
  localparam int CW = 16;

  typedef struct packed {
    logic [2:0]       nl;
    logic [3:0][15:0] len;
    int               stall_at;
    int               stall_len;
    int               restart_at;
    int               exp_n;
    logic [3:0][15:0] exp_we;
    int               exp_done;
    int               exp_cnt_stall;
    int               exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  vec_t vecs[6];

  nn_layer_sequencer_if #(.MAX_LAYERS(ML), .LAYER_W(LW), .CNT_W(CW)) sif ();

  nn_layer_sequencer #(.MAX_LAYERS(ML), .LAYER_W(LW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".counter"}, 32'(sif.counter), 0);
    check({tag, ".pass"}, 32'(sif.pass), 0);
    check({tag, ".layer_we"}, 32'(sif.layer_we), 0);
    check({tag, ".neuron_start"}, 32'(sif.neuron_start), 0);
    check({tag, ".busy"}, 32'(sif.busy), 0);
    check({tag, ".done"}, 32'(sif.done), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ns_n, ns_first, we_n, done_c, busy_d, pass_d, cnt_d;
    int we_c[4];
    int we_v[4];
    ns_n = 0; ns_first = 0; we_n = 0; done_c = 0; busy_d = 1; pass_d = -1; cnt_d = -1;
    for (int i = 0; i < 4; i++) begin we_c[i] = 0; we_v[i] = 0; end
    @(negedge clk);
    sif.num_layers = v.nl;
    sif.layer_len  = v.len;
    sif.start      = 1'b1;
    for (int c = 1; c <= 400 && done_c == 0; c++) begin
      @(negedge clk);
      if (sif.neuron_start) begin
        if (ns_n == 0) ns_first = c;
        ns_n++;
      end
      if (sif.layer_we != '0) begin
        if (we_n < 4) begin we_c[we_n] = c; we_v[we_n] = int'(sif.layer_we); end
        we_n++;
      end
      if (sif.done) begin
        done_c = c; busy_d = int'(sif.busy); pass_d = int'(sif.pass); cnt_d = int'(sif.counter);
      end
      if (v.stall_len > 0 && (c == v.stall_at || c == v.stall_at + v.stall_len))
        check($sformatf("v%0d.stall_counter@%0d", idx, c), 32'(sif.counter), v.exp_cnt_stall);
      sif.stall = (v.stall_len > 0) && (c >= v.stall_at) && (c < v.stall_at + v.stall_len);
      sif.start = (c == v.restart_at);
    end
    sif.start = 1'b0;
    sif.stall = 1'b0;
    check($sformatf("v%0d.neuron_start_first", idx), ns_first, 1);
    check($sformatf("v%0d.neuron_start_count", idx), ns_n, v.exp_n);
    check($sformatf("v%0d.layer_we_count", idx), we_n, v.exp_n);
    for (int i = 0; i < 4; i++)
      if (i < v.exp_n) begin
        check($sformatf("v%0d.we%0d_cycle", idx, i), we_c[i], 32'(v.exp_we[i]));
        check($sformatf("v%0d.we%0d_bit", idx, i), we_v[i], 32'(1) << i);
      end
    check($sformatf("v%0d.done_cycle", idx), done_c, v.exp_done);
    check($sformatf("v%0d.busy_at_done", idx), busy_d, 0);
    check($sformatf("v%0d.pass_at_done", idx), pass_d, v.exp_pass);
    check($sformatf("v%0d.counter_at_done", idx), cnt_d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{nl:3'd3, len:{16'd0, 16'd21, 16'd63, 16'd63}, stall_at:0, stall_len:0, restart_at:40,
                exp_n:3, exp_we:{16'd0, 16'd156, 16'd132, 16'd66}, exp_done:157, exp_cnt_stall:0, exp_pass:2};
    vecs[1] = '{nl:3'd1, len:{16'd0, 16'd0, 16'd0, 16'd0}, stall_at:0, stall_len:0, restart_at:0,
                exp_n:1, exp_we:{16'd0, 16'd0, 16'd0, 16'd3}, exp_done:4, exp_cnt_stall:0, exp_pass:0};
    vecs[2] = '{nl:3'd0, len:{16'd0, 16'd0, 16'd0, 16'd5}, stall_at:0, stall_len:0, restart_at:0,
                exp_n:1, exp_we:{16'd0, 16'd0, 16'd0, 16'd8}, exp_done:9, exp_cnt_stall:0, exp_pass:0};
    vecs[3] = '{nl:3'd7, len:{16'd3, 16'd2, 16'd1, 16'd0}, stall_at:0, stall_len:0, restart_at:0,
                exp_n:4, exp_we:{16'd18, 16'd12, 16'd7, 16'd3}, exp_done:19, exp_cnt_stall:0, exp_pass:3};
    vecs[4] = '{nl:3'd2, len:{16'd0, 16'd0, 16'd4, 16'd10}, stall_at:5, stall_len:5, restart_at:0,
                exp_n:2, exp_we:{16'd0, 16'd0, 16'd25, 16'd18}, exp_done:26, exp_cnt_stall:7, exp_pass:1};
    vecs[5] = '{nl:3'd4, len:{16'd3, 16'd1, 16'd0, 16'd2}, stall_at:0, stall_len:0, restart_at:0,
                exp_n:4, exp_we:{16'd18, 16'd12, 16'd8, 16'd5}, exp_done:19, exp_cnt_stall:0, exp_pass:3};

    sif.start = 1'b0; sif.stall = 1'b0; sif.num_layers = '0; sif.layer_len = '0;
`ifdef NN_SEQ_ABORT_EN
    sif.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_vec(k, vecs[k]);
      @(negedge clk);
      check($sformatf("v%0d.done_pulse_width", k), 32'(sif.done), 0);
    end

    // Asynchronous reset while layer 1 is counting.
    @(negedge clk);
    sif.num_layers = 3'd2;
    sif.layer_len  = {16'd0, 16'd0, 16'd40, 16'd5};
    sif.start      = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sif.start = 1'b0;
    end
    check("midrst.pass_before", 32'(sif.pass), 1);
    check("midrst.counter_before", 32'(sif.counter), 30);
    #1 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_vec(6, vecs[1]);

    // start presented while in DONE must not launch a new inference.
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check("done_start.neuron_start", 32'(sif.neuron_start), 0);
    check("done_start.busy", 32'(sif.busy), 0);
    @(negedge clk);
    check("done_start.busy_later", 32'(sif.busy), 0);

`ifdef NN_SEQ_ABORT_EN
    begin
      int saw_we1, saw_done, saw_ns;
      saw_we1 = 0; saw_done = 0; saw_ns = 0;
      @(negedge clk);
      sif.num_layers = 3'd2;
      sif.layer_len  = {16'd0, 16'd0, 16'd20, 16'd2};
      sif.start      = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        sif.start = (c == 8);
      end
      check("abort.pass_in_run", 32'(sif.pass), 1);
      sif.abort = 1'b1;
      @(negedge clk);
      sif.abort = 1'b0;
      check("abort.aborted", 32'(sif.aborted), 1);
      check("abort.busy", 32'(sif.busy), 0);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (sif.layer_we != '0) saw_we1++;
        if (sif.done) saw_done++;
        if (sif.neuron_start) saw_ns++;
        if (c == 0) check("abort.aborted_width", 32'(sif.aborted), 0);
      end
      check("abort.no_layer_we", saw_we1, 0);
      check("abort.no_done", saw_done, 0);
      check("abort.no_restart", saw_ns, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
